// File: rtl/writeback_arbiter_if.sv
// Bundles the two source handshakes, the regfile write port and the FIFO
// status flags between the producers, the arbiter and decode.
interface writeback_arbiter_if #(
    parameter int REG_COUNT = 32
);
    localparam int ADDR_W = $clog2(REG_COUNT);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]       bus32_t;

    logic      a_valid_i;
    logic      a_ready_o;
    reg_addr_t a_addr_i;
    bus32_t    a_data_i;

    logic      b_valid_i;
    logic      b_ready_o;
    reg_addr_t b_addr_i;
    bus32_t    b_data_i;

    logic      rd_we_o;
    reg_addr_t rd_addr_o;
    bus32_t    rd_data_o;
    logic      bypass_valid_o;

    logic      a_empty_o;
    logic      b_empty_o;

    // Producer/consumer side: drives requests, observes the write port.
    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        input  a_ready_o, b_ready_o,
        input  rd_we_o, rd_addr_o, rd_data_o, bypass_valid_o,
        input  a_empty_o, b_empty_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        output a_ready_o, b_ready_o,
        output rd_we_o, rd_addr_o, rd_data_o, bypass_valid_o,
        output a_empty_o, b_empty_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs drained round-robin into the
// single regfile write port, with x0 writes suppressed and a same-cycle bypass.
module writeback_arbiter_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [31:0]       push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [31:0]       head_data_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign empty_o     = (wptr_q == rptr_q);
    assign full_o      = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                         (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign head_addr_o = addr_mem[rptr_q[IDX_W-1:0]];
    assign head_data_o = data_mem[rptr_q[IDX_W-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone decide which slots are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_mem[wptr_q[IDX_W-1:0]] <= push_addr_i;
            data_mem[wptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end
endmodule

module writeback_arbiter #(
    parameter int DEPTH     = 2,
    parameter int REG_COUNT = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               flush_i,
    writeback_arbiter_if.slave wb
);
    localparam int ADDR_W = $clog2(REG_COUNT);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic              last_grant_q;
    logic              a_full, a_empty, a_push, a_pop;
    logic              b_full, b_empty, b_push, b_pop;
    logic [ADDR_W-1:0] a_head_addr, b_head_addr;
    logic [31:0]       a_head_data, b_head_data;
    logic              grant_a, grant_b;

    // Ready is deliberately independent of valid and of a same-cycle pop.
    assign wb.a_ready_o = !a_full && !flush_i;
    assign wb.b_ready_o = !b_full && !flush_i;
    assign a_push       = wb.a_valid_i && wb.a_ready_o;
    assign b_push       = wb.b_valid_i && wb.b_ready_o;
    assign wb.a_empty_o = a_empty;
    assign wb.b_empty_o = b_empty;

    writeback_arbiter_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_fifo_a (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clear_i    (flush_i),
        .push_i     (a_push),
        .push_addr_i(wb.a_addr_i),
        .push_data_i(wb.a_data_i),
        .pop_i      (a_pop),
        .full_o     (a_full),
        .empty_o    (a_empty),
        .head_addr_o(a_head_addr),
        .head_data_o(a_head_data)
    );

    writeback_arbiter_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_fifo_b (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clear_i    (flush_i),
        .push_i     (b_push),
        .push_addr_i(wb.b_addr_i),
        .push_data_i(wb.b_data_i),
        .pop_i      (b_pop),
        .full_o     (b_full),
        .empty_o    (b_empty),
        .head_addr_o(b_head_addr),
        .head_data_o(b_head_data)
    );

    // On a tie the source that did not win last time gets the port.
    always_comb begin
        grant_a = !a_empty && (b_empty || (last_grant_q == SRC_B));
        grant_b = !b_empty && !grant_a;
    end

    // During a flush the clear supersedes the pop of the granted head.
    assign a_pop = grant_a && !flush_i;
    assign b_pop = grant_b && !flush_i;

    always_comb begin
        wb.rd_we_o   = 1'b0;
        wb.rd_addr_o = '0;
        wb.rd_data_o = '0;
        if (grant_a) begin
            wb.rd_addr_o = a_head_addr;
            wb.rd_data_o = a_head_data;
            wb.rd_we_o   = (a_head_addr != '0);
        end else if (grant_b) begin
            wb.rd_addr_o = b_head_addr;
            wb.rd_data_o = b_head_data;
            wb.rd_we_o   = (b_head_addr != '0);
        end
    end

    assign wb.bypass_valid_o = wb.rd_we_o;

    // x0 grants still count as a turn; a flush leaves the rotation untouched.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_grant_q <= SRC_B;
        end else if (!flush_i && (grant_a || grant_b)) begin
            last_grant_q <= grant_a ? SRC_A : SRC_B;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter: a per-cycle table of inputs and
// hand-computed outputs, plus reset/idle and asynchronous-reset sequences.
module tb_writeback_arbiter;
    localparam int OUT_W = 43;

    typedef struct {
        logic              av;
        logic [4:0]        aa;
        logic [31:0]       ad;
        logic              bv;
        logic [4:0]        ba;
        logic [31:0]       bd;
        logic              fl;
        logic [OUT_W-1:0]  expOut;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    writeback_arbiter_if #(.REG_COUNT(32)) bus ();

    writeback_arbiter #(
        .DEPTH    (2),
        .REG_COUNT(32)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .flush_i(flush),
        .wb     (bus)
    );

    always #5 clk = ~clk;

    // Packs expected outputs; bypass_valid_o is defined as a copy of rd_we_o.
    function automatic logic [OUT_W-1:0] outs(input logic we, input logic [4:0] addr,
                                              input logic [31:0] data, input logic ar,
                                              input logic br, input logic ae, input logic be);
        return {we, addr, data, we, ar, br, ae, be};
    endfunction

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic fl, input logic [OUT_W-1:0] e);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.fl = fl; v.expOut = e;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.a_valid_i = v.av;
        bus.a_addr_i  = v.aa;
        bus.a_data_i  = v.ad;
        bus.b_valid_i = v.bv;
        bus.b_addr_i  = v.ba;
        bus.b_data_i  = v.bd;
        flush         = v.fl;
    endtask

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] expOut);
        logic [OUT_W-1:0] act;
        act = {bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o, bus.bypass_valid_o,
               bus.a_ready_o, bus.b_ready_o, bus.a_empty_o, bus.b_empty_o};
        checks++;
        if (act !== expOut) begin
            failures++;
            $display("[TB] FAIL %s: got we=%0b addr=%0d data=%h byp=%0b ardy=%0b brdy=%0b aemp=%0b bemp=%0b, expected we=%0b addr=%0d data=%h byp=%0b ardy=%0b brdy=%0b aemp=%0b bemp=%0b",
                     name, act[42], act[41:37], act[36:5], act[4], act[3], act[2], act[1], act[0],
                     expOut[42], expOut[41:37], expOut[36:5], expOut[4], expOut[3], expOut[2],
                     expOut[1], expOut[0]);
        end
    endtask

    task automatic stepVector(input string name, input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(name, v.expOut);
    endtask

    initial begin
        logic [OUT_W-1:0] idleOut;
        vec_t             idleVec;

        idleOut = outs(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        idleVec = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, idleOut);

        // Tie after reset, then alternation continues.
        vecs.push_back(mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, idleOut));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd1, 32'h11, 1, 1, 0, 0)));
        vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, outs(1, 5'd2, 32'h22, 1, 1, 1, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd3, 32'h33, 1, 1, 0, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd4, 32'h44, 1, 1, 1, 0)));
        vecs.push_back(idleVec);
        // Single A push: one-cycle latency, then empty again.
        vecs.push_back(mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, idleOut));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd5, 32'hDEADBEEF, 1, 1, 0, 1)));
        vecs.push_back(idleVec);
        // Fill A to DEPTH while B contends; the 0xA03 push is refused once and retried.
        vecs.push_back(mk(1, 5'd6, 32'h601, 1, 5'd7, 32'h701, 0, idleOut));
        vecs.push_back(mk(1, 5'd8, 32'h802, 1, 5'd9, 32'h902, 0, outs(1, 5'd7, 32'h701, 1, 1, 0, 0)));
        vecs.push_back(mk(1, 5'd10, 32'hA03, 1, 5'd11, 32'hB03, 0, outs(1, 5'd6, 32'h601, 0, 1, 0, 0)));
        vecs.push_back(mk(1, 5'd10, 32'hA03, 0, 5'd0, 32'h0, 0, outs(1, 5'd9, 32'h902, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd8, 32'h802, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd11, 32'hB03, 1, 1, 0, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd10, 32'hA03, 1, 1, 0, 1)));
        vecs.push_back(idleVec);
        // x0 write consumes a slot without enabling the regfile.
        vecs.push_back(mk(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0, 0, idleOut));
        vecs.push_back(mk(0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C, 0, outs(0, 5'd0, 32'hFFFF, 1, 1, 0, 1)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd12, 32'hC0C, 1, 1, 1, 0)));
        vecs.push_back(idleVec);
        // Flush with entries queued: the presented head still writes, the rest vanish.
        vecs.push_back(mk(1, 5'd13, 32'hD1, 1, 5'd14, 32'hE1, 0, idleOut));
        vecs.push_back(mk(1, 5'd15, 32'hD2, 1, 5'd16, 32'hE2, 0, outs(1, 5'd13, 32'hD1, 1, 1, 0, 0)));
        vecs.push_back(mk(1, 5'd17, 32'hD3, 0, 5'd0, 32'h0, 1, outs(1, 5'd14, 32'hE1, 0, 0, 0, 0)));
        vecs.push_back(idleVec);
        vecs.push_back(idleVec);
        vecs.push_back(idleVec);
        // Rotation survives the flush: A won last, so B takes the next tie.
        vecs.push_back(mk(1, 5'd18, 32'h1818, 1, 5'd19, 32'h1919, 0, idleOut));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd19, 32'h1919, 1, 1, 0, 0)));
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, outs(1, 5'd18, 32'h1818, 1, 1, 0, 1)));
        vecs.push_back(idleVec);

        rstn = 1'b0;
        applyStimulus(idleVec);
        #2;
        checkOutput("reset_values", idleOut);

        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepVector($sformatf("idle_%0d", i), idleVec);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            stepVector($sformatf("vec_%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle with entries still queued.
        stepVector("async_load", mk(1, 5'd20, 32'h2020, 1, 5'd21, 32'h2121, 0, idleOut));
        stepVector("async_pre", mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,
                                   outs(1, 5'd21, 32'h2121, 1, 1, 0, 0)));
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset", idleOut);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("after_reset_0", idleOut);
        stepVector("after_reset_1", idleVec);
        stepVector("after_reset_2", idleVec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
